// File: rtl/fibonacci_gen.sv
// Iterative Fibonacci generator: a start pulse latches n, then F(0)..F(n) appear
// on fib one term per clock; done pulses on F(n) and overflow flags width wrap.
module fibonacci_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] fib,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] curr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] n_lat;
    logic [WIDTH:0]   sum;
    logic             accept;
    logic             last_step;

    assign sum       = {1'b0, prev} + {1'b0, curr};
    assign count_inc = count + WIDTH'(1);
    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (count_inc == n_lat);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = (n == '0) ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE->DONE only happens on an accepted n==0 start, so done stays a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fib      <= '0;
            prev     <= '0;
            curr     <= WIDTH'(1);
            count    <= '0;
            n_lat    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
            if (accept) begin
                n_lat    <= n;
                fib      <= '0;
                prev     <= '0;
                curr     <= WIDTH'(1);
                count    <= '0;
                overflow <= 1'b0;
            end else if (state == RUN) begin
                fib   <= curr;
                prev  <= curr;
                curr  <= sum[WIDTH-1:0];
                count <= count_inc;
                // On the final step the sum is F(n+1), a lookahead term beyond F(n).
                if (sum[WIDTH] && !last_step) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_gen.sv
// Directed self-checking bench for fibonacci_gen (WIDTH=8) with hand-computed
// Fibonacci terms, completion latency, overflow and asynchronous reset checks.
module tb_fibonacci_gen;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] fib;
    logic             busy;
    logic             done;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    fibonacci_gen #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .fib      (fib),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start; returns at the negedge following the accepting edge.
    task automatic do_start(input logic [WIDTH-1:0] nv);
        start = 1'b1;
        n     = nv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, sampling on negedges; cyc = negedges waited.
    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        n     = '0;
        #1;
        checks++;
        if ({fib, busy, done, overflow} !== {8'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state got fib=%0d busy=%b done=%b ovf=%b exp 0/0/0/0",
                     fib, busy, done, overflow);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({fib, busy, done, overflow} !== {8'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_release got fib=%0d busy=%b done=%b ovf=%b exp 0/0/0/0",
                     fib, busy, done, overflow);
        end
    endtask

    task automatic test_seq7();
        logic [WIDTH-1:0] exp_fib [8];
        exp_fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
        do_start(8'd7);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (fib !== exp_fib[k] || done !== (k == 7) || busy !== (k < 7)) begin
                errors++;
                $display("FAIL seq7 k=%0d got fib=%0d done=%b busy=%b exp fib=%0d done=%b busy=%b",
                         k, fib, done, busy, exp_fib[k], (k == 7), (k < 7));
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL seq7_overflow got %b exp 0", overflow);
        end
        @(negedge clk);
        checks++;
        if (fib !== 8'd13 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq7_hold got fib=%0d done=%b busy=%b exp 13/0/0", fib, done, busy);
        end
    endtask

    task automatic test_n0_n1();
        do_start(8'd0);
        checks++;
        if (fib !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL n0_done got fib=%0d done=%b busy=%b exp 0/1/0", fib, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL n0_pulse got done=%b exp 0", done);
        end
        do_start(8'd1);
        checks++;
        if (fib !== 8'd0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL n1_e0 got fib=%0d done=%b busy=%b exp 0/0/1", fib, done, busy);
        end
        @(negedge clk);
        checks++;
        if (fib !== 8'd1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL n1_done got fib=%0d done=%b busy=%b exp 1/1/0", fib, done, busy);
        end
    endtask

    task automatic test_n13();
        int cyc;
        bit ok;
        do_start(8'd13);
        wait_done(40, cyc, ok);
        checks++;
        if (!ok || cyc != 13) begin
            errors++;
            $display("FAIL n13_latency got ok=%b cycles=%0d exp ok=1 cycles=13", ok, cyc);
        end
        checks++;
        if (fib !== 8'd233 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL n13_value got fib=%0d ovf=%b exp 233/0", fib, overflow);
        end
    endtask

    task automatic test_n14();
        int cyc;
        bit ok;
        @(negedge clk);
        do_start(8'd14);
        wait_done(40, cyc, ok);
        checks++;
        if (!ok || cyc != 14) begin
            errors++;
            $display("FAIL n14_latency got ok=%b cycles=%0d exp ok=1 cycles=14", ok, cyc);
        end
        checks++;
        if (fib !== 8'd121 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL n14_value got fib=%0d ovf=%b exp 121/1", fib, overflow);
        end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || fib !== 8'd121) begin
            errors++;
            $display("FAIL n14_sticky got fib=%0d ovf=%b exp 121/1", fib, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        do_start(8'd10);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL restart_ovf_clear got %b exp 0", overflow);
        end
        repeat (3) @(negedge clk);
        start = 1'b1;
        n     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || fib !== 8'd3) begin
            errors++;
            $display("FAIL restart_ignored got busy=%b fib=%0d exp 1/3", busy, fib);
        end
        wait_done(30, cyc, ok);
        checks++;
        if (!ok || cyc != 6 || fib !== 8'd55) begin
            errors++;
            $display("FAIL n10_done got ok=%b cycles=%0d fib=%0d exp 1/6/55", ok, cyc, fib);
        end
        // Start accepted directly from DONE.
        do_start(8'd3);
        wait_done(10, cyc, ok);
        checks++;
        if (!ok || cyc != 3 || fib !== 8'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL n3_done got ok=%b cycles=%0d fib=%0d ovf=%b exp 1/3/2/0",
                     ok, cyc, fib, overflow);
        end
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        @(negedge clk);
        do_start(8'd14);
        repeat (13) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || fib !== 8'd233) begin
            errors++;
            $display("FAIL midrun_pre got fib=%0d busy=%b ovf=%b exp 233/1/1", fib, busy, overflow);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({fib, busy, done, overflow} !== {8'd0, 3'b000}) begin
            errors++;
            $display("FAIL midrun_async got fib=%0d busy=%b done=%b ovf=%b exp 0/0/0/0",
                     fib, busy, done, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || fib !== 8'd0) begin
            errors++;
            $display("FAIL midrun_abort got activity=%b fib=%0d exp 0/0", saw_done, fib);
        end
    endtask

    initial begin
        test_reset();
        test_seq7();
        test_n0_n1();
        test_n13();
        test_n14();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
